// File: rtl/soma_multibyte.sv
// soma_multibyte: streams a multi-byte addition through an external 8-bit full
// adder. Operand byte pairs arrive LSB first. The block chains the carry between
// bytes and registers each sum byte into a one-entry output stage. On the last
// byte it also reports the final carry, whether the whole sum is zero, and the
// packet length.
module soma_multibyte (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] x_in,
   input  logic [7:0] y_in,
   input  logic       in_last,
   input  logic       cin_init,
   output logic [7:0] add_x,
   output logic [7:0] add_y,
   output logic       add_cin,
   input  logic [7:0] add_s,
   input  logic       add_cout,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic       out_cout,
   output logic       out_zero,
   output logic [7:0] out_nbytes
);

   typedef enum logic {
      ST_FIRST = 1'b0,
      ST_MID   = 1'b1
   } state_t;

   state_t     r_state;
   logic       r_carry;
   logic [7:0] r_count;
   logic       r_zero;
   logic       r_out_valid;
   logic [7:0] r_out_data;
   logic       r_out_last;
   logic       r_out_cout;
   logic       r_out_zero;
   logic [7:0] r_out_nbytes;

   logic       w_first;
   logic       w_accept;
   logic       w_sum_zero;
   logic       w_zero_next;
   logic [7:0] w_count_next;

   assign w_first = (r_state == ST_FIRST);

   // Operands go straight to the external adder.
   // The carry-in switches from the packet carry to the chained carry after the first byte.
   assign add_x   = x_in;
   assign add_y   = y_in;
   assign add_cin = w_first ? cin_init : r_carry;

   // The output stage may refill in the same cycle it drains, so the stream runs at full rate.
   assign in_ready = !rst && (!r_out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   // Running packet facts, including the byte being accepted now.
   assign w_sum_zero   = (add_s == 8'd0);
   assign w_zero_next  = w_first ? w_sum_zero : (r_zero && w_sum_zero);
   assign w_count_next = w_first ? 8'd1
                       : ((r_count == 8'hFF) ? 8'hFF : r_count + 8'd1);

   // Packet state machine, carry chain and registered output stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_FIRST;
         r_carry      <= 1'b0;
         r_count      <= 8'd0;
         r_zero       <= 1'b1;
         r_out_valid  <= 1'b0;
         r_out_data   <= 8'd0;
         r_out_last   <= 1'b0;
         r_out_cout   <= 1'b0;
         r_out_zero   <= 1'b0;
         r_out_nbytes <= 8'd0;
      end else if (w_accept) begin
         r_state      <= in_last ? ST_FIRST : ST_MID;
         r_carry      <= add_cout;
         r_count      <= w_count_next;
         r_zero       <= w_zero_next;
         r_out_valid  <= 1'b1;
         r_out_data   <= add_s;
         r_out_last   <= in_last;
         r_out_cout   <= in_last & add_cout;
         r_out_zero   <= in_last & w_zero_next;
         r_out_nbytes <= in_last ? w_count_next : 8'd0;
      end else if (out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_last   = r_out_last;
   assign out_cout   = r_out_cout;
   assign out_zero   = r_out_zero;
   assign out_nbytes = r_out_nbytes;

endmodule

// File: tb/tb_soma_multibyte.sv
// Testbench for soma_multibyte. It models the external full adder and computes
// each packet's expected bytes from whole-number arithmetic. It then compares
// the result stream, the handshake and the adder carry-in against that model.
module tb_soma_multibyte;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] x_in;
   logic [7:0] y_in;
   logic       in_last;
   logic       cin_init;
   logic [7:0] add_x;
   logic [7:0] add_y;
   logic       add_cin;
   logic [7:0] add_s;
   logic       add_cout;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       out_cout;
   logic       out_zero;
   logic [7:0] out_nbytes;

   always #5 clk = ~clk;

   // External 8-bit full adder.
   assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + {8'd0, add_cin};

   soma_multibyte dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .x_in(x_in), .y_in(y_in), .in_last(in_last), .cin_init(cin_init),
      .add_x(add_x), .add_y(add_y), .add_cin(add_cin), .add_s(add_s),
      .add_cout(add_cout), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .out_cout(out_cout),
      .out_zero(out_zero), .out_nbytes(out_nbytes)
   );

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       c;
      logic       z;
      logic [7:0] nb;
   } exp_t;

   exp_t       q[$];
   exp_t       cur_exp;
   logic       cur_exp_cin;
   logic       m_ov;
   bit         accepted;
   bit         rdy_rand;
   int         hold_cycles;
   int         n_checks;
   int         n_errors;
   logic [7:0] px[8];
   logic [7:0] py[8];
   int         pn;
   logic       pcin;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive out_ready, check everything against the model, then advance the model.
   task automatic tick();
      logic exp_ir;
      if (hold_cycles > 0) begin
         out_ready = 1'b0;
         hold_cycles--;
      end else if (rdy_rand) begin
         out_ready = ($urandom_range(99) < 70);
      end else begin
         out_ready = 1'b1;
      end
      #1;
      exp_ir = !rst && (!m_ov || out_ready);
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov && q.size() > 0) begin
         chk("out_data", 32'(out_data), 32'(q[0].d));
         chk("out_last", 32'(out_last), 32'(q[0].l));
         chk("out_cout", 32'(out_cout), 32'(q[0].c));
         chk("out_zero", 32'(out_zero), 32'(q[0].z));
         chk("out_nbytes", 32'(out_nbytes), 32'(q[0].nb));
      end
      if (in_valid && !rst) begin
         chk("add_x", 32'(add_x), 32'(x_in));
         chk("add_y", 32'(add_y), 32'(y_in));
         chk("add_cin", 32'(add_cin), 32'(cur_exp_cin));
      end
      accepted = in_valid && exp_ir;
      if (rst) begin
         q.delete();
         m_ov = 1'b0;
      end else begin
         if (m_ov && out_ready && q.size() > 0) begin
            $display("beat data=%02h last=%b cout=%b zero=%b nbytes=%0d",
                     q[0].d, q[0].l, q[0].c, q[0].z, q[0].nb);
            void'(q.pop_front());
         end
         if (accepted) begin
            q.push_back(cur_exp);
            m_ov = 1'b1;
         end else if (out_ready) begin
            m_ov = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      x_in     = 8'($urandom);
      y_in     = 8'($urandom);
      in_last  = 1'($urandom);
      cin_init = 1'($urandom);
      tick();
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_out_cout", 32'(out_cout), 32'd0);
      chk("rst_out_zero", 32'(out_zero), 32'd0);
      chk("rst_out_nbytes", 32'(out_nbytes), 32'd0);
   endtask

   task automatic drain();
      int n = 0;
      rdy_rand = 1'b0;
      while (m_ov && n < 20) begin
         idle();
         n++;
      end
      chk("drain_valid", 32'(out_valid), 32'd0);
   endtask

   // Sends the first n_send beats of packet px/py/pn/pcin.
   // mid_cin: 0/1 forces cin_init on the later beats, 2 randomises it.
   task automatic send_pkt(input int n_send, input int gap_pct, input int mid_cin);
      logic [63:0] xv, yv, tot, mask, s;
      xv = 64'd0;
      yv = 64'd0;
      for (int k = 0; k < pn; k++) begin
         xv = xv | (64'(px[k]) << (8 * k));
         yv = yv | (64'(py[k]) << (8 * k));
      end
      tot = xv + yv + 64'(pcin);
      for (int k = 0; k < n_send; k++) begin
         exp_t e;
         int   waited;
         logic last;
         last = (k == pn - 1);
         if (k == 0) begin
            cur_exp_cin = pcin;
         end else begin
            mask = (64'd1 << (8 * k)) - 64'd1;
            s    = (xv & mask) + (yv & mask) + 64'(pcin);
            cur_exp_cin = s[8 * k];
         end
         mask = (64'd1 << (8 * pn)) - 64'd1;
         e.d  = tot[8 * k +: 8];
         e.l  = last;
         e.c  = last ? tot[8 * pn] : 1'b0;
         e.z  = last ? ((tot & mask) == 64'd0) : 1'b0;
         e.nb = last ? 8'(pn) : 8'd0;
         cur_exp = e;
         while ($urandom_range(99) < gap_pct) idle();
         in_valid = 1'b1;
         x_in     = px[k];
         y_in     = py[k];
         in_last  = last;
         if (k == 0)            cin_init = pcin;
         else if (mid_cin == 2) cin_init = 1'($urandom);
         else                   cin_init = 1'(mid_cin);
         waited   = 0;
         accepted = 1'b0;
         while (!accepted && waited < 50) begin
            tick();
            waited++;
         end
         if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
      end
   endtask

   task automatic rand_pkt();
      bit zero_pkt;
      pn       = int'($urandom_range(1, 6));
      zero_pkt = ($urandom_range(3) == 0);
      pcin     = zero_pkt ? 1'b0 : 1'($urandom);
      for (int k = 0; k < pn; k++) begin
         px[k] = 8'($urandom);
         if (zero_pkt) py[k] = (k == 0) ? (~px[k] + 8'd1) : ~px[k];
         else          py[k] = 8'($urandom);
      end
   endtask

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      rst         = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      x_in        = 8'd0;
      y_in        = 8'd0;
      in_last     = 1'b0;
      cin_init    = 1'b0;
      m_ov        = 1'b0;
      rdy_rand    = 1'b0;
      hold_cycles = 0;
      cur_exp     = '0;
      cur_exp_cin = 1'b0;
      @(negedge clk);
      do_reset();

      // Single byte 0x55 + 0xCC + 1.
      pn = 1; pcin = 1'b1; px[0] = 8'h55; py[0] = 8'hCC;
      send_pkt(1, 0, 0);
      drain();

      // 0x00FF + 0x0001: carry ripples into the second byte.
      pn = 2; pcin = 1'b0;
      px[0] = 8'hFF; py[0] = 8'h01; px[1] = 8'h00; py[1] = 8'h00;
      send_pkt(2, 0, 0);
      drain();

      // Single-byte zero sum with a carry out.
      pn = 1; pcin = 1'b0; px[0] = 8'hFF; py[0] = 8'h01;
      send_pkt(1, 0, 0);
      drain();

      // Backpressure: the output stalls for three cycles, then the stream runs back-to-back.
      pn = 5; pcin = 1'b1;
      for (int k = 0; k < 5; k++) begin
         px[k] = 8'($urandom);
         py[k] = 8'($urandom);
      end
      hold_cycles = 4;
      send_pkt(5, 0, 2);
      drain();

      // Reset mid-packet discards the partial sum.
      pn = 2; pcin = 1'b1; px[0] = 8'hFF; py[0] = 8'hFF;
      send_pkt(1, 0, 0);
      do_reset();
      pn = 1; pcin = 1'b0; px[0] = 8'h01; py[0] = 8'h01;
      send_pkt(1, 0, 0);
      drain();

      // cin_init is high only on the later beats; the chained carry must be used instead.
      pn = 3; pcin = 1'b0;
      px[0] = 8'h80; py[0] = 8'h80; px[1] = 8'h10; py[1] = 8'h20;
      px[2] = 8'h00; py[2] = 8'h00;
      send_pkt(3, 0, 1);
      drain();

      // Random packets with idle gaps, random backpressure and occasional aborted packets.
      for (int i = 0; i < 200; i++) begin
         rdy_rand = 1'b1;
         rand_pkt();
         if ($urandom_range(99) < 5) begin
            send_pkt(int'($urandom_range(1, pn)), 30, 2);
            do_reset();
         end else begin
            send_pkt(pn, 30, 2);
         end
      end
      drain();
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/soma_multibyte.md
SOMA_MULTIBYTE -- requirements
Module: soma_multibyte

Interface
REQ-001 The block SHALL have a single clock `clk`; reset `rst` SHALL be synchronous and active-high.
REQ-002 Ports, in order:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `in_valid` in 1: input byte pair present.
- `in_ready` out 1: block accepts the pair this cycle.
- `x_in` in 8: operand X byte, LSB byte of the packet first.
- `y_in` in 8: operand Y byte.
- `in_last` in 1: this pair is the MSB byte of the packet.
- `cin_init` in 1: packet carry-in, used on the first byte only.
- `add_x` out 8: to the external 8-bit full adder `x`.
- `add_y` out 8: to adder `y`.
- `add_cin` out 1: to adder `Cin`.
- `add_s` in 8: from adder `A`.
- `add_cout` in 1: from adder `Cout`.
- `out_valid` out 1: result byte present.
- `out_ready` in 1: downstream accepts the result byte.
- `out_data` out 8: sum byte.
- `out_last` out 1: MSB byte of the packet.
- `out_cout` out 1: final carry, valid when `out_last`=1, else 0.
- `out_zero` out 1: whole multi-byte sum is zero, valid when `out_last`=1, else 0.
- `out_nbytes` out 8: packet length in bytes, valid when `out_last`=1, else 0.

Function
REQ-003 The adder path SHALL be combinational: `add_x`=`x_in`, `add_y`=`y_in`; `add_cin`=`cin_init` in FIRST, else the carry register.
REQ-004 FSM states: FIRST (expect first byte) and MID (inside packet).
- Accepted beat with `in_last`=0 -> MID.
- Accepted beat with `in_last`=1 -> FIRST.
- No accepted beat -> hold state.
REQ-005 Handshake: a beat is accepted when `in_valid` && `in_ready`.
- `in_ready` = !`out_valid` || `out_ready` (one-entry output register, full-throughput).
REQ-006 On acceptance, these SHALL be registered in the same edge:
- `out_data`<=`add_s`; `out_last`<=`in_last`; `out_valid`<=1.
- Latency: one cycle from acceptance to `out_valid`.
REQ-007 Carry register SHALL load `add_cout` on every accepted beat.
REQ-008 Byte counter SHALL:
- Load 1 on a FIRST beat.
- Increment on a MID beat, saturating at 255.
- `out_nbytes` SHALL present the count including the last byte.
REQ-009 Zero accumulator SHALL:
- Load (`add_s`==0) on a FIRST beat.
- AND (`add_s`==0) into itself on a MID beat.
- `out_zero` SHALL reflect it on the last beat.
- Final carry does not affect `out_zero`.
REQ-010 `out_cout`<=`add_cout` when `in_last`=1, else 0.
REQ-011 If `out_valid`=1 and `out_ready`=0, all `out_*` SHALL hold stable and `in_ready`=0.
REQ-012 If `out_ready`=1 and no beat is accepted, `out_valid` SHALL clear next cycle.
REQ-013 Simultaneous output drain and new acceptance SHALL keep `out_valid`=1 with the new data; no bubble.
REQ-014 A single-beat packet (FIRST with `in_last`=1) SHALL be legal. It yields `out_nbytes`=1 and ends in FIRST.
REQ-015 When `in_valid`=0, the adder outputs SHALL be ignored and no internal state SHALL change.

Reset
REQ-016 With `rst`=1 at a clock edge, the block SHALL reset:
- State -> FIRST.
- Carry, counter and all `out_*` -> 0.
- Zero accumulator -> 1.
REQ-017 While `rst`=1, `in_ready` SHALL be 0.
REQ-018 Reset mid-packet SHALL discard the partial packet; the next accepted beat is a FIRST beat.

Verification
REQ-019 Single byte: `x_in`=0x55, `y_in`=0xCC, `cin_init`=1, `in_last`=1.
- Next cycle: `out_data`=0x22, `out_cout`=1, `out_zero`=0, `out_nbytes`=1.
REQ-020 Two bytes, 0x00FF+0x0001, `cin_init`=0.
- Beats (FF,01) then (00,00,last).
- Outputs 0x00, then 0x01 with `out_cout`=0, `out_zero`=0, `out_nbytes`=2.
- `add_cin`=1 on the second beat.
REQ-021 Zero sum: (0xFF,0x01), `cin_init`=0, `last`.
- `out_data`=0x00, `out_cout`=1, `out_zero`=1.
REQ-022 Backpressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1.
- `in_ready`=0; `out_*` stable.
- After release, back-to-back beats stream at 1 per cycle with no loss.
REQ-023 Reset mid-packet: send (0xFF,0xFF) not last, assert `rst` one cycle, then send (0x01,0x01,last) with `cin_init`=0.
- `out_data`=0x02, `out_nbytes`=1, `out_cout`=0.
REQ-024 Cin isolation: set `cin_init`=1 only during the MID beats of a three-byte packet.
- `add_cin` on those beats equals the carry register, not `cin_init`.
